iomem_wb_bridge: RTL and testbench
==================================

// Module: iomem_wb_bridge
// PURPOSE
// - Parametrised bridge from the picosoc iomem bus to NUM_CH address-decoded Wishbone classic slave channels.
// - Sits between picosoc and peripherals such as wb_hyperram.
// - Decodes iomem_addr[31:24] against per-channel base bytes and runs one registered WB cycle per request.
// - Returns the slave's read data on iomem_rdata.
// - Adds an ack timeout and decode-miss error reporting.
// PARAMETERS
// - NUM_CH      4              number of WB channels (1..8).
// - CH_BASE     {8'h33,8'h32,8'h31,8'h30}  packed NUM_CH*8 bits; byte k = addr[31:24] base of channel k.
// - TIMEOUT     255            cycles to wait for ack before aborting; 0 = never time out.
// - MISS_RDATA  32'h0000_0000  iomem_rdata on decode miss.
// - TO_RDATA    32'hFFFF_FFFF  iomem_rdata on timeout.
// PORTS
// - clk          in   1         system clock (also the WB clock).
// - resetn       in   1         asynchronous reset, active low.
// - iomem_valid  in   1         picosoc request valid.
// - iomem_ready  out  1         one-cycle response strobe.
// - iomem_wstrb  in   4         byte write strobes; 0 = read.
// - iomem_addr   in   32        byte address.
// - iomem_wdata  in   32        write data.
// - iomem_rdata  out  32        read data, valid while iomem_ready=1.
// - wbm_cyc_o    out  NUM_CH    per-channel CYC.
// - wbm_stb_o    out  NUM_CH    per-channel STB.
// - wbm_we_o     out  1         shared WE.
// - wbm_sel_o    out  4         shared SEL.
// - wbm_adr_o    out  32        shared address.
// - wbm_dat_o    out  32        shared write data.
// - wbm_dat_i    in   NUM_CH*32 per-channel read data; slice k = channel k.
// - wbm_ack_i    in   NUM_CH    per-channel ACK.
// - bus_err_o    out  1         one-cycle pulse on miss or timeout.
// - gpio_o       out  32        GPIO register; present only with IOMEM_BRIDGE_GPIO_EN.
// BEHAVIOUR
// - Reset values: all outputs 0; FSM forced to IDLE.
// - Reset asserted mid-cycle abandons any WB cycle; cyc/stb drop immediately.
// - FSM states:
//   - IDLE: on iomem_valid, decode addr[31:24].
//     - Lowest-index matching channel wins.
//     - Hit: register adr/dat, we=|wstrb, sel=(we ? wstrb : 4'hF); enter BUS.
//     - Miss: enter RESP with MISS_RDATA and err flagged.
//   - BUS: cyc[k]=stb[k]=1, all other channels 0.
//     - On ack_i[k]: capture dat_i slice k, drop cyc/stb at the next edge, enter RESP.
//     - Timeout counter increments each BUS cycle.
//     - Counter reaching TIMEOUT without ack: drop cyc/stb, enter RESP with TO_RDATA and err flagged.
//     - Ack and timeout in the same cycle: ack wins.
//   - RESP: iomem_ready=1 for exactly one cycle with registered rdata.
//     - bus_err_o pulses in this same cycle if flagged.
//     - Next state is IDLE.
//   - IDLE ignores iomem_valid in the cycle immediately after RESP (one-cycle turnaround guard).
// - Latency: valid sampled at edge N; stb high in cycle N+1.
//   - Ack in that cycle gives iomem_ready in cycle N+2.
//   - Each additional wait state adds 1 cycle.
// - Stability: WB outputs are registered and held stable for the whole BUS state.
//   - iomem inputs may change after the IDLE sample edge.
// - Ack from a non-selected channel is ignored.
// - Timeout counter width is clog2(TIMEOUT+1); it clears on entry to BUS and saturates.
// - Exactly one channel is active at a time; there are no outstanding or pipelined transfers.
// CONFIGURATION
// - Macro IOMEM_BRIDGE_GPIO_EN defined:
//   - Adds gpio_o and an internal 32-bit register decoded at addr[31:24]==8'h03, checked before the channels.
//   - Access goes IDLE->RESP with no WB cycle.
//   - Write updates bytes per wstrb; read returns the register value before the write.
//   - Reset value 0.
// - Macro not defined: the gpio_o port does not exist and 8'h03 decodes as a normal channel or a miss.
// TESTING
// - Read ch1 (addr 32'h3100_0010), slave acks first cycle with 32'hCAFE_F00D:
//   - adr=32'h3100_0010, sel=4'hF, we=0;
//   - iomem_ready 2 cycles after valid, rdata=32'hCAFE_F00D.
// - Write 32'h1234_5678, wstrb=4'b0011 to ch0, ack after 3 wait states:
//   - sel=4'b0011, we=1, stb held stable 4 cycles;
//   - ready at cycle 5; only cyc[0] ever high.
// - Access addr 32'h4000_0000 (miss): ready the cycle after IDLE sample, rdata=0, bus_err_o=1 one cycle, no cyc.
// - TIMEOUT=8, ch2 never acks: stb high exactly 8 cycles, then ready with rdata=32'hFFFF_FFFF and bus_err_o pulse.
// - resetn low while in BUS: cyc/stb/ready drop asynchronously; after release a new ch3 read completes normally.
// - With IOMEM_BRIDGE_GPIO_EN, write 32'hA5 (wstrb 4'b0001) to 32'h0300_0000:
//   - gpio_o=32'h0000_00A5;
//   - readback returns 32'hA5;
//   - no WB activity.

Source files
------------

// File: rtl/iomem_wb_bridge.sv
// rtl/iomem_wb_bridge.sv - picosoc iomem to NUM_CH-channel Wishbone classic bridge
// Defining IOMEM_BRIDGE_GPIO_EN adds a 32-bit GPIO register at addr[31:24]==8'h03 and the gpio_o port.
module iomem_wb_bridge #(
   parameter int                  NUM_CH     = 4,
   parameter logic [NUM_CH*8-1:0] CH_BASE    = {8'h33, 8'h32, 8'h31, 8'h30},
   parameter int                  TIMEOUT    = 255,
   parameter logic [31:0]         MISS_RDATA = 32'h0000_0000,
   parameter logic [31:0]         TO_RDATA   = 32'hFFFF_FFFF
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 iomem_valid,
   output logic                 iomem_ready,
   input  logic [3:0]           iomem_wstrb,
   input  logic [31:0]          iomem_addr,
   input  logic [31:0]          iomem_wdata,
   output logic [31:0]          iomem_rdata,
   output logic [NUM_CH-1:0]    wbm_cyc_o,
   output logic [NUM_CH-1:0]    wbm_stb_o,
   output logic                 wbm_we_o,
   output logic [3:0]           wbm_sel_o,
   output logic [31:0]          wbm_adr_o,
   output logic [31:0]          wbm_dat_o,
   input  logic [NUM_CH*32-1:0] wbm_dat_i,
   input  logic [NUM_CH-1:0]    wbm_ack_i,
   output logic                 bus_err_o
`ifdef IOMEM_BRIDGE_GPIO_EN
  ,output logic [31:0]          gpio_o
`endif
);

   localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] CNT_MAX = (TIMEOUT > 0) ? CW'(TIMEOUT) : CW'(1);
   localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : CW'(0);
`ifdef IOMEM_BRIDGE_GPIO_EN
   localparam logic [7:0] GPIO_BASE = 8'h03;
`endif

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t            state;
   logic [NUM_CH-1:0] act;
   logic [IW-1:0]     ch_idx;
   logic [CW-1:0]     cnt;
   logic              guard;
   logic              hit;
   logic [IW-1:0]     hit_idx;
   logic              ack_hit;
   logic              to_hit;
   logic [31:0]       ack_data;

   assign wbm_cyc_o = act;
   assign wbm_stb_o = act;

   // Descending scan so the lowest matching channel index is the one left standing.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         if (iomem_addr[31:24] == CH_BASE[k*8 +: 8]) begin
            hit     = 1'b1;
            hit_idx = IW'(k);
         end
      end
   end

   always_comb begin
      ack_data = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (ch_idx == IW'(k)) ack_data = wbm_dat_i[k*32 +: 32];
      end
   end

   assign ack_hit = |(wbm_ack_i & act);
   assign to_hit  = (TIMEOUT != 0) && (cnt == TO_LAST);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= IDLE;
         act         <= '0;
         ch_idx      <= '0;
         cnt         <= '0;
         guard       <= 1'b0;
         iomem_ready <= 1'b0;
         iomem_rdata <= '0;
         wbm_we_o    <= 1'b0;
         wbm_sel_o   <= '0;
         wbm_adr_o   <= '0;
         wbm_dat_o   <= '0;
         bus_err_o   <= 1'b0;
`ifdef IOMEM_BRIDGE_GPIO_EN
         gpio_o      <= '0;
`endif
      end else begin
         iomem_ready <= 1'b0;
         bus_err_o   <= 1'b0;
         case (state)
            IDLE: begin
               guard <= 1'b0;
               if (iomem_valid && !guard) begin
`ifdef IOMEM_BRIDGE_GPIO_EN
                  if (iomem_addr[31:24] == GPIO_BASE) begin
                     iomem_rdata <= gpio_o;
                     for (int b = 0; b < 4; b++) begin
                        if (iomem_wstrb[b]) gpio_o[b*8 +: 8] <= iomem_wdata[b*8 +: 8];
                     end
                     iomem_ready <= 1'b1;
                     state       <= RESP;
                  end else
`endif
                  if (hit) begin
                     act       <= NUM_CH'(1) << hit_idx;
                     ch_idx    <= hit_idx;
                     cnt       <= '0;
                     wbm_adr_o <= iomem_addr;
                     wbm_dat_o <= iomem_wdata;
                     wbm_we_o  <= |iomem_wstrb;
                     wbm_sel_o <= (|iomem_wstrb) ? iomem_wstrb : 4'hF;
                     state     <= BUS;
                  end else begin
                     iomem_rdata <= MISS_RDATA;
                     iomem_ready <= 1'b1;
                     bus_err_o   <= 1'b1;
                     state       <= RESP;
                  end
               end
            end
            BUS: begin
               // Ack is tested first so a same-cycle ack beats the timeout.
               if (ack_hit) begin
                  act         <= '0;
                  iomem_rdata <= ack_data;
                  iomem_ready <= 1'b1;
                  state       <= RESP;
               end else if (to_hit) begin
                  act         <= '0;
                  iomem_rdata <= TO_RDATA;
                  iomem_ready <= 1'b1;
                  bus_err_o   <= 1'b1;
                  state       <= RESP;
               end else if (cnt != CNT_MAX) begin
                  cnt <= cnt + 1'b1;
               end
            end
            RESP: begin
               guard <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_iomem_wb_bridge.sv
// tb/tb_iomem_wb_bridge.sv - table-driven bench for iomem_wb_bridge with TIMEOUT=8
// Exercises the GPIO register only when IOMEM_BRIDGE_GPIO_EN is defined.
module tb_iomem_wb_bridge;

   logic         clk = 1'b0;
   logic         resetn;
   logic         iomem_valid;
   logic         iomem_ready;
   logic [3:0]   iomem_wstrb;
   logic [31:0]  iomem_addr;
   logic [31:0]  iomem_wdata;
   logic [31:0]  iomem_rdata;
   logic [3:0]   wbm_cyc_o;
   logic [3:0]   wbm_stb_o;
   logic         wbm_we_o;
   logic [3:0]   wbm_sel_o;
   logic [31:0]  wbm_adr_o;
   logic [31:0]  wbm_dat_o;
   logic [127:0] wbm_dat_i;
   logic [3:0]   wbm_ack_i;
   logic         bus_err_o;
`ifdef IOMEM_BRIDGE_GPIO_EN
   logic [31:0]  gpio_o;
`endif

   int total  = 0;
   int passed = 0;

   int          wcnt [4];
   int          sl_delay;
   logic [3:0]  stray;
   logic [31:0] sdat [4];

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
      int          delay;
      logic [3:0]  stray;
      logic [31:0] sdata;
      int          lat;
      logic [31:0] rdata;
      int          err;
      int          stb_n;
      logic [3:0]  mask;
      logic [3:0]  sel;
      logic        we;
   } vec_t;

   vec_t vecs [7];

   iomem_wb_bridge #(.TIMEOUT(8)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .iomem_valid (iomem_valid),
      .iomem_ready (iomem_ready),
      .iomem_wstrb (iomem_wstrb),
      .iomem_addr  (iomem_addr),
      .iomem_wdata (iomem_wdata),
      .iomem_rdata (iomem_rdata),
      .wbm_cyc_o   (wbm_cyc_o),
      .wbm_stb_o   (wbm_stb_o),
      .wbm_we_o    (wbm_we_o),
      .wbm_sel_o   (wbm_sel_o),
      .wbm_adr_o   (wbm_adr_o),
      .wbm_dat_o   (wbm_dat_o),
      .wbm_dat_i   (wbm_dat_i),
      .wbm_ack_i   (wbm_ack_i),
      .bus_err_o   (bus_err_o)
`ifdef IOMEM_BRIDGE_GPIO_EN
     ,.gpio_o      (gpio_o)
`endif
   );

   always #5 clk = ~clk;

   // Slave model: channel k acks after sl_delay wait states; stray forces acks regardless of stb.
   always @(posedge clk) begin
      for (int k = 0; k < 4; k++) wcnt[k] <= wbm_stb_o[k] ? wcnt[k] + 1 : 0;
   end

   always_comb begin
      wbm_ack_i = '0;
      wbm_dat_i = '0;
      for (int k = 0; k < 4; k++) begin
         wbm_ack_i[k]          = (wbm_stb_o[k] && (wcnt[k] == sl_delay)) || stray[k];
         wbm_dat_i[k*32 +: 32] = sdat[k];
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
      else passed++;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic run_txn(input vec_t v, input string nm);
      int          n, stb_n, err_n;
      logic        got, stable, first;
      logic [3:0]  mask, sel0;
      logic        we0;
      logic [31:0] rd, adr0, dat0;
      iomem_valid = 1'b0;
      repeat (3) tick();
      sl_delay = v.delay;
      stray    = v.stray;
      for (int k = 0; k < 4; k++) sdat[k] = v.mask[k] ? v.sdata : (32'hBAD0_0000 | k);
      iomem_addr  = v.addr;
      iomem_wstrb = v.wstrb;
      iomem_wdata = v.wdata;
      iomem_valid = 1'b1;
      n = 0; stb_n = 0; err_n = 0; got = 1'b0; stable = 1'b1; first = 1'b1;
      mask = '0; sel0 = '0; we0 = 1'b0; rd = '0; adr0 = '0; dat0 = '0;
      while (!got && n < 40) begin
         tick();
         n++;
         if (|wbm_stb_o) begin
            stb_n++;
            if (first) begin
               adr0 = wbm_adr_o; sel0 = wbm_sel_o; we0 = wbm_we_o; dat0 = wbm_dat_o;
               first = 1'b0;
            end else if (adr0 !== wbm_adr_o || sel0 !== wbm_sel_o || we0 !== wbm_we_o ||
                         dat0 !== wbm_dat_o) begin
               stable = 1'b0;
            end
         end
         mask = mask | wbm_cyc_o | wbm_stb_o;
         if (bus_err_o) err_n++;
         if (iomem_ready) begin
            got = 1'b1;
            rd  = iomem_rdata;
         end
         if (n == 1) begin
            iomem_addr  = ~v.addr;
            iomem_wdata = ~v.wdata;
            iomem_wstrb = ~v.wstrb;
         end
      end
      iomem_valid = 1'b0;
      stray       = '0;
      tick();
      if (bus_err_o) err_n++;
      mask = mask | wbm_cyc_o;
      chk({nm, "_done"}, 32'(got), 32'd1);
      chk({nm, "_lat"}, n, v.lat);
      chk({nm, "_rdata"}, rd, v.rdata);
      chk({nm, "_err"}, err_n, v.err);
      chk({nm, "_stb_cycles"}, stb_n, v.stb_n);
      chk({nm, "_cyc_mask"}, 32'(mask), 32'(v.mask));
      chk({nm, "_ready_pulse"}, 32'(iomem_ready), 32'd0);
      if (v.mask != 4'd0) begin
         chk({nm, "_adr"}, adr0, v.addr);
         chk({nm, "_sel"}, 32'(sel0), 32'(v.sel));
         chk({nm, "_we"}, 32'(we0), 32'(v.we));
         chk({nm, "_stable"}, 32'(stable), 32'd1);
         if (v.we) chk({nm, "_wdat"}, dat0, v.wdata);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [5:0] rdy_pat, err_pat;
      vec_t g;

      vecs[0] = '{32'h3100_0010, 4'h0,    32'h0000_0000, 0,   4'h0,    32'hCAFE_F00D,
                  2, 32'hCAFE_F00D, 0, 1, 4'b0010, 4'hF,    1'b0};
      vecs[1] = '{32'h3000_0004, 4'b0011, 32'h1234_5678, 3,   4'h0,    32'h5555_0000,
                  5, 32'h5555_0000, 0, 4, 4'b0001, 4'b0011, 1'b1};
      vecs[2] = '{32'h4000_0000, 4'h0,    32'h0000_0000, 0,   4'h0,    32'h0,
                  1, 32'h0000_0000, 1, 0, 4'b0000, 4'h0,    1'b0};
      vecs[3] = '{32'h3200_0100, 4'h0,    32'h0000_0000, 255, 4'b1000, 32'h1111_2222,
                  9, 32'hFFFF_FFFF, 1, 8, 4'b0100, 4'hF,    1'b0};
      vecs[4] = '{32'h33AB_CDEF, 4'h0,    32'h0000_0000, 1,   4'h0,    32'h0BAD_BEEF,
                  3, 32'h0BAD_BEEF, 0, 2, 4'b1000, 4'hF,    1'b0};
      vecs[5] = '{32'h3200_0000, 4'hF,    32'h8765_4321, 7,   4'h0,    32'hDEAD_0001,
                  9, 32'hDEAD_0001, 0, 8, 4'b0100, 4'hF,    1'b1};
      vecs[6] = '{32'h2F00_0000, 4'b0001, 32'h0000_00FF, 0,   4'h0,    32'h0,
                  1, 32'h0000_0000, 1, 0, 4'b0000, 4'h0,    1'b0};

      resetn = 1'b0; iomem_valid = 1'b0; iomem_wstrb = '0; iomem_addr = '0; iomem_wdata = '0;
      sl_delay = 0; stray = '0;
      for (int k = 0; k < 4; k++) sdat[k] = '0;
      repeat (3) tick();
      chk("rst_ready", 32'(iomem_ready), 32'd0);
      chk("rst_err", 32'(bus_err_o), 32'd0);
      chk("rst_cyc_stb", 32'({wbm_cyc_o, wbm_stb_o}), 32'd0);
      chk("rst_adr", wbm_adr_o, 32'd0);
      chk("rst_rdata", iomem_rdata, 32'd0);
      chk("rst_we_sel", 32'({wbm_we_o, wbm_sel_o}), 32'd0);
      @(negedge clk) resetn = 1'b1;
      tick();

      for (int i = 0; i < 7; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

      // Valid held high through a miss: the cycle after RESP is the turnaround and is ignored.
      repeat (3) tick();
      iomem_addr = 32'h4000_0000; iomem_wstrb = '0; iomem_valid = 1'b1;
      rdy_pat = '0; err_pat = '0;
      for (int i = 0; i < 6; i++) begin
         tick();
         rdy_pat = {rdy_pat[4:0], iomem_ready};
         err_pat = {err_pat[4:0], bus_err_o};
      end
      iomem_valid = 1'b0;
      chk("guard_ready_pattern", 32'(rdy_pat), 32'(6'b100100));
      chk("guard_err_pattern", 32'(err_pat), 32'(6'b100100));

      // Asynchronous reset while ch3 is mid-cycle.
      repeat (3) tick();
      sl_delay = 255;
      iomem_addr = 32'h3300_0000; iomem_wstrb = '0; iomem_valid = 1'b1;
      repeat (3) tick();
      chk("rstbus_stb_before", 32'(wbm_stb_o), 32'(4'b1000));
      #2 resetn = 1'b0;
      #1;
      chk("rstbus_cyc_stb", 32'({wbm_cyc_o, wbm_stb_o}), 32'd0);
      chk("rstbus_ready", 32'(iomem_ready), 32'd0);
      iomem_valid = 1'b0;
      @(negedge clk) resetn = 1'b1;
      tick();
      g = '{32'h3300_0040, 4'h0, 32'h0, 0, 4'h0, 32'h7777_3333,
            2, 32'h7777_3333, 0, 1, 4'b1000, 4'hF, 1'b0};
      run_txn(g, "post_rst");

`ifdef IOMEM_BRIDGE_GPIO_EN
      g = '{32'h0300_0000, 4'b0001, 32'h0000_00A5, 0, 4'h0, 32'h0,
            1, 32'h0000_0000, 0, 0, 4'b0000, 4'h0, 1'b0};
      run_txn(g, "gpio_wr");
      chk("gpio_val_a5", gpio_o, 32'h0000_00A5);
      g = '{32'h0300_0000, 4'b0000, 32'h0, 0, 4'h0, 32'h0,
            1, 32'h0000_00A5, 0, 0, 4'b0000, 4'h0, 1'b0};
      run_txn(g, "gpio_rd");
      g = '{32'h0300_0000, 4'b0010, 32'h0000_5A00, 0, 4'h0, 32'h0,
            1, 32'h0000_00A5, 0, 0, 4'b0000, 4'h0, 1'b0};
      run_txn(g, "gpio_wr2");
      chk("gpio_val_5aa5", gpio_o, 32'h0000_5AA5);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
